// File: rtl/riscv_fwd_pkg.sv
// ============================================================================
// Module      : riscv_fwd_pkg
// Description : Shared constants and the stage-record type for the EX-stage
//               forwarding control (select-code bit positions, x0 index,
//               {valid, rd, regwen} record used by the EX and WB trackers).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_fwd_pkg;

  // Bit positions inside the 2-bit asel/bsel select codes.
  localparam int ASEL_FWD_BIT = 1;  // forward wb_val onto the rs1 path
  localparam int ASEL_PC_BIT  = 0;  // ALU operand A takes PC
  localparam int BSEL_FWD_BIT = 1;  // forward wb_val onto the rs2 path
  localparam int BSEL_IMM_BIT = 0;  // ALU operand B takes the immediate

  // Architectural zero register; never a forwarding source.
  localparam int REG_X0 = 0;

  // Register index width of the default core configuration.
  localparam int REG_IDX_W = 5;

  // Per-stage tracking record. Bubbles are the all-zero record.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwen;
  } stage_rec_t;

endpackage

`default_nettype wire

// File: rtl/fwd_stage_reg.sv
// ============================================================================
// Module      : fwd_stage_reg
// Description : One pipeline stage-record register with hold and bubble
//               controls. Bubble wins over hold so a redirect can squash a
//               frozen stage.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               hold        - keep the current record
//               bubble      - load the all-zero (invalid) record
//               d           - record loaded when neither hold nor bubble
//               q           - registered record
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import riscv_fwd_pkg::*;

module fwd_stage_reg #(
  parameter type REC_T = stage_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic bubble,
  input  REC_T d,
  output REC_T q
);

  REC_T rec_q;
  REC_T rec_d;

  always_comb begin
    rec_d = rec_q;
    if (bubble) begin
      rec_d = '0;
    end else if (!hold) begin
      rec_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign q = rec_q;

endmodule

`default_nettype wire

// File: rtl/ex_fwd_ctrl.sv
// ============================================================================
// Module      : ex_fwd_ctrl
// Description : Control side of the EX-stage forwarding mux for a 3-stage
//               (ID/EX/WB) core. Tracks the EX and WB occupants, and registers
//               the asel/bsel select codes at ID->EX capture so they are
//               stable for the whole EX cycle of their instruction.
// Ports       : clk, rst                  - clock, sync active-high reset
//               id_*                      - ID-stage register usage fields
//               stall, flush              - freeze EX/WB, bubble into EX
//               asel, bsel                - {forward, pc/imm} select codes
//               ex_*/wb_*                 - stage tracking state
//               fwd_a_cnt, fwd_b_cnt      - forwarding event counters
// Options     : FWD_PERF_CNT_EN - when defined, the forwarding event counters
//               are implemented; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import riscv_fwd_pkg::*;

module ex_fwd_ctrl #(
  parameter int XLEN_CNT  = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NREG_BITS-1:0] id_rs1,
  input  logic [NREG_BITS-1:0] id_rs2,
  input  logic [NREG_BITS-1:0] id_rd,
  input  logic                 id_regwen,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_a_is_pc,
  input  logic                 id_b_is_imm,
  input  logic                 stall,
  input  logic                 flush,
  output logic [1:0]           asel,
  output logic [1:0]           bsel,
  output logic                 ex_valid,
  output logic [NREG_BITS-1:0] ex_rd,
  output logic                 ex_regwen,
  output logic                 wb_valid,
  output logic [NREG_BITS-1:0] wb_rd,
  output logic                 wb_regwen,
  output logic [XLEN_CNT-1:0]  fwd_a_cnt,
  output logic [XLEN_CNT-1:0]  fwd_b_cnt
);

  // Same layout as stage_rec_t, sized by this instance's NREG_BITS.
  typedef struct packed {
    logic                 valid;
    logic [NREG_BITS-1:0] rd;
    logic                 regwen;
  } rec_t;

  localparam logic [NREG_BITS-1:0] X0_IDX = NREG_BITS'(REG_X0);

  rec_t id_rec;
  rec_t ex_rec;
  rec_t wb_rec;
  logic ex_bubble;

  assign id_rec = '{valid: id_valid, rd: id_rd, regwen: id_regwen};

  // Flush squashes EX even while frozen; an empty ID slot only becomes a
  // bubble when the pipe actually advances.
  assign ex_bubble = flush | (~stall & ~id_valid);

  fwd_stage_reg #(.REC_T(rec_t)) u_ex_stage (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall),
    .bubble (ex_bubble),
    .d      (id_rec),
    .q      (ex_rec)
  );

  // WB only ever holds or follows EX; it is never squashed.
  fwd_stage_reg #(.REC_T(rec_t)) u_wb_stage (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall),
    .bubble (1'b0),
    .d      (ex_rec),
    .q      (wb_rec)
  );

  // --------------------------------------------------------------------------
  // Select codes. The current EX occupant is the one that will sit in WB
  // during the incoming instruction's EX cycle, so it is the forward source.
  // --------------------------------------------------------------------------
  logic       ex_is_writer;
  logic       fwd_a;
  logic       fwd_b;
  logic [1:0] asel_q, asel_d;
  logic [1:0] bsel_q, bsel_d;

  assign ex_is_writer = ex_rec.valid & ex_rec.regwen & (ex_rec.rd != X0_IDX);
  assign fwd_a        = id_uses_rs1 & ex_is_writer & (ex_rec.rd == id_rs1);
  assign fwd_b        = id_uses_rs2 & ex_is_writer & (ex_rec.rd == id_rs2);

  always_comb begin
    asel_d = asel_q;
    bsel_d = bsel_q;
    if (flush) begin
      asel_d = 2'b00;
      bsel_d = 2'b00;
    end else if (!stall) begin
      if (id_valid) begin
        asel_d[ASEL_FWD_BIT] = fwd_a;
        asel_d[ASEL_PC_BIT]  = id_a_is_pc;
        bsel_d[BSEL_FWD_BIT] = fwd_b;
        bsel_d[BSEL_IMM_BIT] = id_b_is_imm;
      end else begin
        asel_d = 2'b00;
        bsel_d = 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asel_q <= 2'b00;
      bsel_q <= 2'b00;
    end else begin
      asel_q <= asel_d;
      bsel_q <= bsel_d;
    end
  end

  assign asel      = asel_q;
  assign bsel      = bsel_q;
  assign ex_valid  = ex_rec.valid;
  assign ex_rd     = ex_rec.rd;
  assign ex_regwen = ex_rec.regwen;
  assign wb_valid  = wb_rec.valid;
  assign wb_rd     = wb_rec.rd;
  assign wb_regwen = wb_rec.regwen;

  // --------------------------------------------------------------------------
  // Forwarding event counters. An event is counted once, on the cycle its
  // instruction leaves EX, so a frozen EX entry is not counted repeatedly.
  // --------------------------------------------------------------------------
`ifdef FWD_PERF_CNT_EN
  logic [XLEN_CNT-1:0] fwd_a_cnt_q, fwd_a_cnt_d;
  logic [XLEN_CNT-1:0] fwd_b_cnt_q, fwd_b_cnt_d;

  always_comb begin
    fwd_a_cnt_d = fwd_a_cnt_q;
    fwd_b_cnt_d = fwd_b_cnt_q;
    if (!stall && ex_rec.valid) begin
      if (asel_q[ASEL_FWD_BIT]) fwd_a_cnt_d = fwd_a_cnt_q + XLEN_CNT'(1);
      if (bsel_q[BSEL_FWD_BIT]) fwd_b_cnt_d = fwd_b_cnt_q + XLEN_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_cnt_q <= '0;
      fwd_b_cnt_q <= '0;
    end else begin
      fwd_a_cnt_q <= fwd_a_cnt_d;
      fwd_b_cnt_q <= fwd_b_cnt_d;
    end
  end

  assign fwd_a_cnt = fwd_a_cnt_q;
  assign fwd_b_cnt = fwd_b_cnt_q;
`else
  assign fwd_a_cnt = '0;
  assign fwd_b_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_fwd_ctrl.sv
// ============================================================================
// Module      : tb_ex_fwd_ctrl
// Description : Directed self-checking bench for ex_fwd_ctrl. Inputs change
//               1 time unit after the rising edge; outputs are checked at
//               that same point, away from the active edge.
// Options     : FWD_PERF_CNT_EN - selects the expected counter values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwen, id_uses_rs1, id_uses_rs2, id_a_is_pc, id_b_is_imm;
  logic       stall, flush;
  logic [1:0] asel, bsel;
  logic       ex_valid, ex_regwen, wb_valid, wb_regwen;
  logic [4:0] ex_rd, wb_rd;
  logic [31:0] fwd_a_cnt, fwd_b_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_a_cnt = 0;
  int exp_b_cnt = 0;

  always #5 clk = ~clk;

  ex_fwd_ctrl #(.XLEN_CNT(32), .NREG_BITS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwen   (id_regwen),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_a_is_pc  (id_a_is_pc),
    .id_b_is_imm (id_b_is_imm),
    .stall       (stall),
    .flush       (flush),
    .asel        (asel),
    .bsel        (bsel),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_regwen   (ex_regwen),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_regwen   (wb_regwen),
    .fwd_a_cnt   (fwd_a_cnt),
    .fwd_b_cnt   (fwd_b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counter expectations depend on whether the counters are built.
  task automatic chk_cnt(input string tag);
`ifdef FWD_PERF_CNT_EN
    chk({tag, "_a_cnt"}, fwd_a_cnt, exp_a_cnt);
    chk({tag, "_b_cnt"}, fwd_b_cnt, exp_b_cnt);
`else
    chk({tag, "_a_cnt"}, fwd_a_cnt, 32'd0);
    chk({tag, "_b_cnt"}, fwd_b_cnt, 32'd0);
`endif
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic wen,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic apc, input logic bimm);
    id_valid = v;    id_rd = rd;       id_regwen = wen;
    id_rs1 = r1;     id_uses_rs1 = u1;
    id_rs2 = r2;     id_uses_rs2 = u2;
    id_a_is_pc = apc; id_b_is_imm = bimm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Reset state
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ex_rd",    ex_rd,    0);
    chk("rst_wb_rd",    wb_rd,    0);
    chk("rst_asel",     asel,     0);
    chk("rst_bsel",     bsel,     0);
    chk_cnt("rst");
    rst = 1'b0;

    // addi x5, x0, imm
    set_id(1, 5, 1, 0, 1, 0, 0, 0, 1); tick();
    chk("addi_ex_valid", ex_valid, 1);
    chk("addi_ex_rd",    ex_rd,    5);
    chk("addi_asel",     asel,     2'b00);
    chk("addi_bsel",     bsel,     2'b01);
    chk("addi_wb_valid", wb_valid, 0);

    // add x6, x5, x7 : rs1 forwarded from the addi
    set_id(1, 6, 1, 5, 1, 7, 1, 0, 0); tick();
    chk("dep_asel",     asel,     2'b10);
    chk("dep_bsel",     bsel,     2'b00);
    chk("dep_wb_rd",    wb_rd,    5);
    chk("dep_wb_valid", wb_valid, 1);
    chk("dep_ex_rd",    ex_rd,    6);

    // x0 writer; the add leaves EX with a forward on A
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    exp_a_cnt = 1;
    chk("x0w_ex_regwen", ex_regwen, 1);
    chk("x0w_ex_rd",     ex_rd,     0);
    chk_cnt("x0w");

    // reader of x0 on both sources: never forwarded
    set_id(1, 12, 1, 0, 1, 0, 1, 0, 0); tick();
    chk("x0r_asel", asel, 2'b00);
    chk("x0r_bsel", bsel, 2'b00);

    // writer x3, then AUIPC-style reader of x3 with imm
    set_id(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 4, 1, 3, 1, 0, 0, 1, 1); tick();
    chk("auipc_asel", asel, 2'b11);
    chk("auipc_bsel", bsel, 2'b01);

    // writer x10, then reader of rs2 = x10
    set_id(1, 10, 1, 0, 0, 0, 0, 0, 0); tick();
    exp_a_cnt = 2;
    chk_cnt("auipc_done");
    set_id(1, 13, 1, 0, 0, 10, 1, 0, 0); tick();
    chk("rs2dep_asel", asel, 2'b00);
    chk("rs2dep_bsel", bsel, 2'b10);

    // writer x8, then flush with a reader of x8 in ID
    set_id(1, 8, 1, 0, 0, 0, 0, 0, 0); tick();
    exp_b_cnt = 1;
    chk_cnt("rs2dep_done");
    set_id(1, 14, 1, 0, 0, 8, 1, 0, 0); flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_bsel",     bsel,     2'b00);
    chk("flush_wb_rd",    wb_rd,    8);
    chk("flush_wb_valid", wb_valid, 1);

    // writer x9, reader of x9, then freeze the reader's EX for 3 cycles
    set_id(1, 9, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("post_flush_wb_valid", wb_valid, 0);
    set_id(1, 15, 1, 9, 1, 0, 0, 0, 0); tick();
    chk("stall_pre_asel", asel, 2'b10);
    chk("stall_pre_wb_rd", wb_rd, 9);
    stall = 1'b1;
    set_id(1, 16, 1, 0, 0, 15, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_asel",  asel,  2'b10);
      chk("stall_wb_rd", wb_rd, 9);
      chk("stall_ex_rd", ex_rd, 15);
      chk_cnt("stall_hold");
    end
    stall = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    exp_a_cnt = 3;
    chk("stall_rel_ex_valid", ex_valid, 0);
    chk_cnt("stall_rel");

    // stall together with flush: EX squashed, selects cleared, WB held
    set_id(1, 20, 1, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 21, 1, 0, 0, 0, 0, 0, 1); tick();
    set_id(1, 22, 1, 20, 1, 0, 0, 1, 1);
    stall = 1'b1; flush = 1'b1; tick();
    stall = 1'b0; flush = 1'b0;
    chk("stfl_ex_valid", ex_valid, 0);
    chk("stfl_asel",     asel,     2'b00);
    chk("stfl_bsel",     bsel,     2'b00);
    chk("stfl_wb_rd",    wb_rd,    20);
    chk("stfl_wb_valid", wb_valid, 1);

    // reset during a stall, with a pending dependency on x11
    set_id(1, 11, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("prerst_ex_rd", ex_rd, 11);
    set_id(1, 17, 1, 11, 1, 0, 0, 0, 0);
    rst = 1'b1; stall = 1'b1; tick();
    exp_a_cnt = 0; exp_b_cnt = 0;
    chk("mrst_ex_valid", ex_valid, 0);
    chk("mrst_wb_valid", wb_valid, 0);
    chk("mrst_ex_rd",    ex_rd,    0);
    chk("mrst_wb_rd",    wb_rd,    0);
    chk("mrst_asel",     asel,     0);
    chk("mrst_bsel",     bsel,     0);
    chk_cnt("mrst");
    rst = 1'b0; stall = 1'b0; tick();
    chk("postrst_asel",     asel,     2'b00);
    chk("postrst_ex_valid", ex_valid, 1);
    chk("postrst_ex_rd",    ex_rd,    17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
